// File: rtl/decode_control_pipe.sv
// RV32I main decoder feeding D->E->M->W control registers, with load-use
// stall detection and branch-flush bubble insertion in front of execute.
module decode_control_pipe #(
  parameter int ALU_OP_W   = 3,
  parameter int REG_ADDR_W = 5,
  parameter int EXTENDED   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid_D,
  input  logic [6:0]              opcode_D,
  input  logic [REG_ADDR_W-1:0]   rd_D,
  input  logic [REG_ADDR_W-1:0]   rs1_D,
  input  logic [REG_ADDR_W-1:0]   rs2_D,
  input  logic                    flush_E,
  output logic                    illegal_D,
  output logic                    stall_FD,
  output logic                    flush_D,
  output logic [11+ALU_OP_W-1:0]  ctrl_E,
  output logic                    valid_E,
  output logic [REG_ADDR_W-1:0]   rd_E,
  output logic                    reg_write_M,
  output logic                    mem_write_M,
  output logic [1:0]              result_src_M,
  output logic [REG_ADDR_W-1:0]   rd_M,
  output logic                    valid_M,
  output logic                    reg_write_W,
  output logic [1:0]              result_src_W,
  output logic [REG_ADDR_W-1:0]   rd_W,
  output logic                    valid_W
);

  localparam int CW = 11 + ALU_OP_W;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic          reg_write, alu_src_a, alu_src_b, mem_write, branch, jump;
  logic [1:0]    result_src;
  logic [2:0]    imm_src;
  logic [2:0]    alu_op3;
  logic          legal, uses_rs1, uses_rs2;
  logic [CW-1:0] ctrl_D;
  logic [1:0]    result_src_E;
  logic          load_use, bubble;

  always_comb begin
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    jump       = 1'b0;
    imm_src    = 3'b000;
    alu_op3    = 3'b000;
    legal      = 1'b1;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    case (opcode_D)
      OP_R:      begin reg_write = 1'b1; alu_op3 = 3'b010; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_I:      begin reg_write = 1'b1; alu_src_b = 1'b1; alu_op3 = 3'b001; uses_rs1 = 1'b1; end
      OP_LOAD:   begin reg_write = 1'b1; alu_src_b = 1'b1; result_src = 2'b01; uses_rs1 = 1'b1; end
      OP_STORE:  begin alu_src_b = 1'b1; mem_write = 1'b1; imm_src = 3'b001;
                       uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin branch = 1'b1; imm_src = 3'b010; alu_op3 = 3'b011;
                       uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JAL:    begin reg_write = 1'b1; result_src = 2'b10; jump = 1'b1; imm_src = 3'b011; end
      OP_JALR:   begin reg_write = 1'b1; alu_src_b = 1'b1; result_src = 2'b10; jump = 1'b1;
                       uses_rs1 = 1'b1; end
      OP_LUI:    begin reg_write = 1'b1; alu_src_b = 1'b1; imm_src = 3'b100; alu_op3 = 3'b100; end
      OP_AUIPC:  begin reg_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 1'b1; imm_src = 3'b100; end
      default:   legal = 1'b0;
    endcase
    if (EXTENDED == 0 && opcode_D != OP_R && opcode_D != OP_I) legal = 1'b0;
    // illegal opcodes carry an all-zero bundle and never claim source registers
    if (!legal) begin
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      mem_write  = 1'b0;
      result_src = 2'b00;
      branch     = 1'b0;
      jump       = 1'b0;
      imm_src    = 3'b000;
      alu_op3    = 3'b000;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
    end
  end

  assign ctrl_D = {reg_write, alu_src_a, alu_src_b, mem_write, result_src,
                   branch, jump, imm_src, ALU_OP_W'(alu_op3)};

  assign illegal_D    = instr_valid_D & ~legal;
  assign result_src_E = ctrl_E[CW-5:CW-6];

  assign load_use = valid_E & (result_src_E == 2'b01) & (rd_E != '0) & instr_valid_D &
                    ((uses_rs1 & (rs1_D == rd_E)) | (uses_rs2 & (rs2_D == rd_E)));

  // flush wins: a wrong-path D instruction is discarded, never held
  assign stall_FD = load_use & ~flush_E;
  assign flush_D  = flush_E;
  assign bubble   = flush_E | load_use | ~instr_valid_D | illegal_D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_E       <= '0;
      rd_E         <= '0;
      valid_E      <= 1'b0;
      reg_write_M  <= 1'b0;
      mem_write_M  <= 1'b0;
      result_src_M <= 2'b00;
      rd_M         <= '0;
      valid_M      <= 1'b0;
      reg_write_W  <= 1'b0;
      result_src_W <= 2'b00;
      rd_W         <= '0;
      valid_W      <= 1'b0;
    end else begin
      if (bubble) begin
        ctrl_E  <= '0;
        rd_E    <= '0;
        valid_E <= 1'b0;
      end else begin
        ctrl_E  <= ctrl_D;
        rd_E    <= rd_D;
        valid_E <= 1'b1;
      end
      reg_write_M  <= ctrl_E[CW-1];
      mem_write_M  <= ctrl_E[CW-4];
      result_src_M <= result_src_E;
      rd_M         <= rd_E;
      valid_M      <= valid_E;
      reg_write_W  <= reg_write_M;
      result_src_W <= result_src_M;
      rd_W         <= rd_M;
      valid_W      <= valid_M;
    end
  end

endmodule
